note_tone_generator: RTL and testbench
======================================

Name: note_tone_generator

Overview:
Consumer end of the 4-bit note-code interface driven by the audio sequencer. Converts the note code (A..G, rest, end-of-sequence) into a square-wave speaker drive with volume PWM and an amplifier enable. Glitch-filters the short rest codes the sequencer emits between consecutive notes, so a note is not chopped. Sits between the sequencer and the board's mono audio pin.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz; half-period table derived from it at elaboration.
MUTE_HOLD, 4, consecutive mute-code cycles required before a sounding tone is silenced (min 1).
HALF_W, 17, width of the half-period / phase counters.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
enable  input  1  audio enable; low forces silence and amp off
noteSelect  input  4  note code: 0=A 1=B 2=C 3=D 4=E 5=F 6=G 7=rest 8=end; 9-15 treated as rest
volume  input  3  PWM duty during the high half of the square: (volume+1)/8
audioOut  output  1  registered speaker drive
ampEnable  output  1  registered amplifier enable = enable delayed one cycle
toneActive  output  1  high while in TONE
activeNote  output  4  code currently sounding; 7 when silent

Behaviour:
- Reset (reset==0 at an edge): state SILENT, audioOut=0, ampEnable=0, toneActive=0, activeNote=7.
- Reset clears noteReg=7, phase=0, sq=0, muteCnt=0, pwmCnt=0. Reset mid-tone kills output on that edge.
- Half-period table, integer floor of CLK_HZ/(2*f):
  A=440, B=494, C=523, D=587, E=659, F=698, G=784 Hz.
  At 100 MHz: A=113636, B=101214, C=95602, D=85178, E=75872, F=71633, G=63775.
- Input stage: noteSelect is registered into noteReg every edge. The FSM acts only on noteReg, giving 2-edge latency from pin to audioOut.
- pwmCnt: 3-bit free-running counter, wraps 7->0.
- State SILENT:
  - If enable and noteReg<=6: go to TONE, activeNote=noteReg, half=table[noteReg], phase=0, sq=1, muteCnt=0.
- State TONE:
  - phase increments each cycle. When phase==half-1, phase clears and sq toggles, so each half lasts exactly half cycles.
  - noteReg<=6 and noteReg!=activeNote: immediate switch. Reload half, phase=0, sq=1, muteCnt=0.
  - noteReg==activeNote: continue with no phase disturbance; muteCnt=0.
  - noteReg>=7: muteCnt increments while the tone keeps running. When muteCnt reaches MUTE_HOLD-1 and noteReg is still mute, go to SILENT next edge: sq=0, phase=0, activeNote=7.
  - A valid code appearing before the hold expires cancels the mute: same code continues, different code switches.
- enable==0: go to SILENT from any state on the next edge, overriding all other transitions.
- audioOut is registered as sq & toneActive & enable & (pwmCnt<=volume). volume=7 gives a clean square.
- toneActive is high exactly in TONE. ampEnable is enable registered, independent of state.
- Code 8 (end) behaves exactly as rest; no special handling.

Test Plan:
CLK_HZ=8800 (A half=10, B=8, G=5), MUTE_HOLD=4, volume=7.
1. Reset release, noteSelect=0 from edge 0 -> audioOut rises at edge 2; high 10 cycles, low 10 cycles, repeating; activeNote=0, toneActive=1.
2. Tone A running, noteSelect=7 for 2 cycles then 0 again -> no gap in audioOut, phase continuous, toneActive stays 1.
3. Tone A running, noteSelect=8 held -> TONE kept through MUTE_HOLD-1 mute cycles, then SILENT; audioOut=0, activeNote=7.
4. A to G switch mid-high-half -> 2 edges after the change, phase restarts with audioOut high, halves of 5 cycles, activeNote=6.
5. volume=0 during tone -> within each high half, audioOut high 1 cycle of every 8 (pwmCnt==0); low half stays 0.
6. enable dropped mid-tone, and separately reset=0 mid-tone -> enable: SILENT next edge, ampEnable 0 one cycle after. Reset: all outputs at reset values on that edge, and the tone restarts only 2 edges after release.

Source files
------------

// File: rtl/note_tone_generator.sv
// Square-wave tone generator driven by the sequencer's 4-bit note codes.
// Short rest codes between notes are filtered so a sounding note is not chopped.
module note_tone_generator #(
  parameter int CLK_HZ    = 100000000,
  parameter int MUTE_HOLD = 4,
  parameter int HALF_W    = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] noteSelect,
  input  logic [2:0] volume,
  output logic       audioOut,
  output logic       ampEnable,
  output logic       toneActive,
  output logic [3:0] activeNote
);

  localparam int MUTE_CW = (MUTE_HOLD < 2) ? 1 : $clog2(MUTE_HOLD);

  function automatic int half_calc(input int freq);
    int h;
    h = CLK_HZ / (2 * freq);
    if (h < 1) h = 1;
    return h;
  endfunction

  localparam logic [HALF_W-1:0] HALF_A = HALF_W'(half_calc(440));
  localparam logic [HALF_W-1:0] HALF_B = HALF_W'(half_calc(494));
  localparam logic [HALF_W-1:0] HALF_C = HALF_W'(half_calc(523));
  localparam logic [HALF_W-1:0] HALF_D = HALF_W'(half_calc(587));
  localparam logic [HALF_W-1:0] HALF_E = HALF_W'(half_calc(659));
  localparam logic [HALF_W-1:0] HALF_F = HALF_W'(half_calc(698));
  localparam logic [HALF_W-1:0] HALF_G = HALF_W'(half_calc(784));

  localparam logic [3:0] NOTE_SILENT = 4'd7;

  function automatic logic [HALF_W-1:0] half_lookup(input logic [3:0] note);
    logic [HALF_W-1:0] h;
    case (note)
      4'd0:    h = HALF_A;
      4'd1:    h = HALF_B;
      4'd2:    h = HALF_C;
      4'd3:    h = HALF_D;
      4'd4:    h = HALF_E;
      4'd5:    h = HALF_F;
      4'd6:    h = HALF_G;
      default: h = HALF_A;
    endcase
    return h;
  endfunction

  typedef enum logic {
    SILENT = 1'b0,
    TONE   = 1'b1
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [3:0]          note_reg;
  logic [3:0]          active_q;
  logic [3:0]          active_n;
  logic [HALF_W-1:0]   half_q;
  logic [HALF_W-1:0]   half_n;
  logic [HALF_W-1:0]   phase_q;
  logic [HALF_W-1:0]   phase_n;
  logic                sq_q;
  logic                sq_n;
  logic [MUTE_CW-1:0]  mute_q;
  logic [MUTE_CW-1:0]  mute_n;
  logic [2:0]          pwm_q;
  logic [2:0]          pwm_n;
  logic                audio_n;
  logic                note_valid;
  logic                note_same;
  logic                mute_expired;
  logic                half_end;

  assign note_valid   = (note_reg <= 4'd6);
  assign note_same    = (note_reg == active_q);
  assign mute_expired = (mute_q == MUTE_CW'(MUTE_HOLD - 1));
  assign half_end     = (phase_q == half_q - HALF_W'(1));
  assign pwm_n        = pwm_q + 3'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= SILENT;
    else        state <= state_n;
  end

  // Next-state logic; a low enable overrides every other transition.
  always_comb begin
    state_n = state;
    case (state)
      SILENT:  if (note_valid) state_n = TONE;
      TONE:    if (!note_valid && mute_expired) state_n = SILENT;
      default: state_n = SILENT;
    endcase
    if (!enable) state_n = SILENT;
  end

  // Output / datapath logic: values that phase, square and note take on the next edge.
  always_comb begin
    phase_n  = phase_q;
    sq_n     = sq_q;
    half_n   = half_q;
    active_n = active_q;
    mute_n   = mute_q;
    if (state_n == SILENT) begin
      phase_n  = '0;
      sq_n     = 1'b0;
      active_n = NOTE_SILENT;
      mute_n   = '0;
    end else if (state == SILENT || (note_valid && !note_same)) begin
      half_n   = half_lookup(note_reg);
      active_n = note_reg;
      phase_n  = '0;
      sq_n     = 1'b1;
      mute_n   = '0;
    end else begin
      // Tone keeps its phase through rest codes until the hold runs out.
      if (half_end) begin
        phase_n = '0;
        sq_n    = ~sq_q;
      end else begin
        phase_n = phase_q + HALF_W'(1);
      end
      mute_n = note_valid ? '0 : mute_q + MUTE_CW'(1);
    end
    audio_n = sq_n & (state_n == TONE) & enable & (pwm_n <= volume);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      note_reg  <= NOTE_SILENT;
      active_q  <= NOTE_SILENT;
      half_q    <= '0;
      phase_q   <= '0;
      sq_q      <= 1'b0;
      mute_q    <= '0;
      pwm_q     <= 3'd0;
      audioOut  <= 1'b0;
      ampEnable <= 1'b0;
    end else begin
      note_reg  <= noteSelect;
      active_q  <= active_n;
      half_q    <= half_n;
      phase_q   <= phase_n;
      sq_q      <= sq_n;
      mute_q    <= mute_n;
      pwm_q     <= pwm_n;
      audioOut  <= audio_n;
      ampEnable <= enable;
    end
  end

  assign toneActive = (state == TONE);
  assign activeNote = active_q;

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator: timestamp-based tone model feeding a scoreboard,
// plus directed scenarios with hand-computed waveform checks.
module tb_note_tone_generator;

  localparam int CLK_HZ    = 8800;
  localparam int MUTE_HOLD = 4;
  localparam int HALF_W    = 17;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] noteSelect = 4'd7;
  logic [2:0] volume = 3'd7;
  logic       audioOut;
  logic       ampEnable;
  logic       toneActive;
  logic [3:0] activeNote;

  int checks = 0;
  int errors = 0;

  note_tone_generator #(
    .CLK_HZ(CLK_HZ),
    .MUTE_HOLD(MUTE_HOLD),
    .HALF_W(HALF_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .noteSelect(noteSelect),
    .volume(volume),
    .audioOut(audioOut),
    .ampEnable(ampEnable),
    .toneActive(toneActive),
    .activeNote(activeNote)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Model: a tone started at edge m_start with half-period h is high on
  // edges where ((n - m_start) / h) is even.
  function automatic int half_of(input int note);
    int f;
    case (note)
      0: f = 440;
      1: f = 494;
      2: f = 523;
      3: f = 587;
      4: f = 659;
      5: f = 698;
      default: f = 784;
    endcase
    return CLK_HZ / (2 * f);
  endfunction

  logic [6:0] exp_q[$];
  int n = 0;
  int m_sel = 7;
  int m_cur = 7;
  int m_start = 0;
  int m_mute = 0;
  int m_pwm0 = 0;

  always @(posedge clk) begin
    int  code;
    logic aud;
    n++;
    if (!reset) begin
      m_sel  = 7;
      m_cur  = 7;
      m_mute = 0;
      m_pwm0 = n;
      exp_q.push_back({1'b0, 1'b0, 1'b0, 4'd7});
    end else begin
      code = m_sel;
      if (!enable) begin
        m_cur  = 7;
        m_mute = 0;
      end else if (m_cur == 7) begin
        if (code <= 6) begin
          m_cur   = code;
          m_start = n;
          m_mute  = 0;
        end
      end else if (code <= 6) begin
        if (code != m_cur) begin
          m_cur   = code;
          m_start = n;
        end
        m_mute = 0;
      end else if (m_mute == MUTE_HOLD - 1) begin
        m_cur  = 7;
        m_mute = 0;
      end else begin
        m_mute++;
      end
      m_sel = int'(noteSelect);
      aud = 1'b0;
      if (m_cur != 7 && enable)
        aud = ((((n - m_start) / half_of(m_cur)) % 2) == 0) &&
              (((n - m_pwm0) % 8) <= int'(volume));
      exp_q.push_back({aud, enable, (m_cur != 7), 4'(m_cur)});
    end
  end

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    logic [6:0] exp_v;
    logic [6:0] act_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got empty queue expected entry at %0t", $time);
    end else begin
      exp_v = exp_q.pop_front();
      act_v = {audioOut, ampEnable, toneActive, activeNote};
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cmp at %0t: got aud=%b amp=%b tone=%b note=%0d expected aud=%b amp=%b tone=%b note=%0d",
                 $time, act_v[6], act_v[5], act_v[4], act_v[3:0],
                 exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
      end
    end
  end

  // Driver / directed-check tasks
  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive_at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input logic lvl, input string name);
    int k;
    k = 0;
    while (audioOut !== lvl && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check(name, int'(audioOut), int'(lvl));
  endtask

  task automatic run_len(output int len);
    logic lvl;
    lvl = audioOut;
    len = 0;
    while (audioOut === lvl && len < 200) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int len;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_audio", int'(audioOut), 0);
    check("rst_amp", int'(ampEnable), 0);
    check("rst_tone", int'(toneActive), 0);
    check("rst_note", int'(activeNote), 7);

    // 1: release with A, two-edge latency, 10/10 halves
    drive_at_edge();
    reset = 1'b1;
    noteSelect = 4'd0;
    @(posedge clk);
    @(negedge clk);
    check("t1_lat_tone", int'(toneActive), 0);
    check("t1_lat_audio", int'(audioOut), 0);
    @(negedge clk);
    check("t1_rise_audio", int'(audioOut), 1);
    check("t1_rise_note", int'(activeNote), 0);
    check("t1_rise_tone", int'(toneActive), 1);
    run_len(len);
    check("t1_high_len", len, 10);
    run_len(len);
    check("t1_low_len", len, 10);
    run_len(len);
    check("t1_high2_len", len, 10);

    // 2: two rest cycles are filtered
    repeat (3) @(negedge clk);
    drive_at_edge();
    noteSelect = 4'd7;
    drive_at_edge();
    drive_at_edge();
    noteSelect = 4'd0;
    repeat (4) @(negedge clk);
    check("t2_tone_kept", int'(toneActive), 1);
    check("t2_note_kept", int'(activeNote), 0);

    // 3: end code held silences after the hold
    repeat (5) @(negedge clk);
    drive_at_edge();
    noteSelect = 4'd8;
    repeat (4) @(posedge clk);
    #1;
    check("t3_hold_tone", int'(toneActive), 1);
    @(posedge clk);
    #1;
    check("t3_silent_tone", int'(toneActive), 0);
    check("t3_silent_note", int'(activeNote), 7);
    check("t3_silent_audio", int'(audioOut), 0);

    // 4: A -> G switch mid-high-half
    drive_at_edge();
    noteSelect = 4'd0;
    wait_level(1'b1, "t4_wait_high");
    repeat (3) @(posedge clk);
    #1;
    noteSelect = 4'd6;
    repeat (2) @(posedge clk);
    #1;
    check("t4_switch_note", int'(activeNote), 6);
    check("t4_switch_audio", int'(audioOut), 1);
    @(negedge clk);
    run_len(len);
    check("t4_g_high_len", len, 5);
    run_len(len);
    check("t4_g_low_len", len, 5);

    // 5: minimum volume PWM, checked by the model
    drive_at_edge();
    volume = 3'd0;
    repeat (60) @(posedge clk);
    #1;
    volume = 3'd7;

    // 6a: enable drop and recovery
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b0;
    drive_at_edge();
    check("t6_en_tone", int'(toneActive), 0);
    check("t6_en_amp", int'(ampEnable), 0);
    check("t6_en_audio", int'(audioOut), 0);
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b1;
    drive_at_edge();
    check("t6_en_resume_tone", int'(toneActive), 1);
    check("t6_en_resume_amp", int'(ampEnable), 1);

    // 6b: reset mid-tone, restart two edges after release
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    drive_at_edge();
    check("t6_rst_audio", int'(audioOut), 0);
    check("t6_rst_tone", int'(toneActive), 0);
    check("t6_rst_note", int'(activeNote), 7);
    reset = 1'b1;
    drive_at_edge();
    check("t6_rel_tone", int'(toneActive), 0);
    drive_at_edge();
    check("t6_rel2_tone", int'(toneActive), 1);
    check("t6_rel2_audio", int'(audioOut), 1);

    // Out-of-range codes act as rest: brief gap filtered, then hold expires
    repeat (3) @(posedge clk);
    #1;
    noteSelect = 4'd12;
    repeat (2) @(posedge clk);
    #1;
    noteSelect = 4'd6;
    repeat (6) @(posedge clk);
    #1;
    noteSelect = 4'd15;
    repeat (10) @(posedge clk);
    #1;
    check("t7_rest15_tone", int'(toneActive), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
